line_memory: RTL and testbench

- Backing-store responder at the far end of the cache's line-fill/write-back interface.
- Serves whole 4-word (64-bit) line reads and writes after a fixed, parameterised latency; signals completion with a one-cycle done pulse.
- Sits between the cache (initiator: readM/writeM/address_memory/64-bit line bus) and nothing else; it is the simulation memory model and the synthesizable BRAM-backed store.

---
 rtl/line_memory_pkg.sv | 25 ++
 rtl/line_memory_if.sv | 26 ++
 rtl/line_mem_array.sv | 37 +++
 rtl/line_memory.sv | 117 +++++++++++
 tb/tb_line_memory.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_memory_pkg.sv
// Shared constants and types for the line_memory backing store.
//   WORD_SIZE / LINE_W : 16-bit words, 4 per line (64-bit line bus)
//   word_msb()         : bit position of word k's MSB (word 0 is the top word)
//   state_e            : responder FSM states
package line_memory_pkg;

  localparam int unsigned WORD_SIZE       = 16;
  localparam int unsigned WORDS_PER_LINE  = 4;
  localparam int unsigned LINE_W          = WORDS_PER_LINE * WORD_SIZE;
  localparam int unsigned ADDR_W          = 16;
  localparam int unsigned LATENCY_DEFAULT = 4;
  localparam int unsigned CNT_W           = 4;  // holds LATENCY up to 15

  // Word 0 sits in [63:48], word 3 in [15:0].
  function automatic int unsigned word_msb(input int unsigned k);
    return LINE_W - 1 - k * WORD_SIZE;
  endfunction

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/line_memory_if.sv
// Cache <-> line memory line-fill/write-back bus.
//   master : cache side, drives readM/writeM/address_memory/data_in
//   slave  : memory side, drives data_out/mem_done/busy/proto_err
interface line_memory_if;
  import line_memory_pkg::*;

  logic              readM;
  logic              writeM;
  logic [ADDR_W-1:0] address_memory;
  logic [LINE_W-1:0] data_in;
  logic [LINE_W-1:0] data_out;
  logic              mem_done;
  logic              busy;
  logic              proto_err;

  modport master (
    output readM, writeM, address_memory, data_in,
    input  data_out, mem_done, busy, proto_err
  );

  modport slave (
    input  readM, writeM, address_memory, data_in,
    output data_out, mem_done, busy, proto_err
  );

endinterface

// File: rtl/line_mem_array.sv
// Single-port synchronous line RAM, 64 bits x 2**LINE_ADDR_W, registered read.
//   clk, reset_n : clock; async reset clears only the read register, never the array
//   addr         : line index shared by read and write
//   we / wdata   : write line on the rising edge
//   re / rdata   : capture array[addr] into the read register on the rising edge
module line_mem_array
  import line_memory_pkg::*;
#(
  parameter int unsigned LINE_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [LINE_ADDR_W-1:0] addr,
  input  logic                   we,
  input  logic                   re,
  input  logic [LINE_W-1:0]      wdata,
  output logic [LINE_W-1:0]      rdata
);

  logic [LINE_W-1:0] mem [2**LINE_ADDR_W];
  logic [LINE_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_memory.sv
// Backing-store responder for whole-line reads and writes after LATENCY cycles.
//   clk, reset_n          : clock, asynchronous active-low reset
//   bus (slave)           : request/line bus; mem_done pulses one cycle per request
//   num_reads, num_writes : saturating counts of completed reads / writes
module line_memory
  import line_memory_pkg::*;
#(
  parameter int unsigned LATENCY     = LATENCY_DEFAULT,
  parameter int unsigned LINE_ADDR_W = 14
) (
  input  logic          clk,
  input  logic          reset_n,
  line_memory_if.slave  bus,
  output logic [15:0]   num_reads,
  output logic [15:0]   num_writes
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("line_memory: LATENCY must be in 1..15");
  end

  localparam logic [CNT_W-1:0] LastCount = CNT_W'(LATENCY - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   op_write_q;
  logic [LINE_ADDR_W-1:0] idx_q;
  logic [LINE_W-1:0]      wline_q;
  logic                   proto_err_q;
  logic [15:0]            num_reads_q, num_writes_q;

  logic                   req, accept, done_entry, cur_write;
  logic [LINE_ADDR_W-1:0] live_idx, ram_addr;
  logic [LINE_W-1:0]      ram_wdata, ram_rdata;
  logic                   ram_we, ram_re;
  logic                   unused_addr;

  // Upper address bits wrap and bits [1:0] select a word within the line.
  assign live_idx    = bus.address_memory[LINE_ADDR_W+1:2];
  assign unused_addr = ^bus.address_memory;

  assign req    = bus.readM | bus.writeM;
  assign accept = (state_q == StIdle) && req;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          count_d = CNT_W'(1);
          state_d = (LATENCY == 1) ? StDone : StBusy;
        end
      end
      StBusy: begin
        count_d = count_q + CNT_W'(1);
        if (count_q == LastCount) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With LATENCY==1 the DONE-entry edge is the acceptance edge, so the RAM
  // must see the live request rather than the not-yet-latched copy.
  assign cur_write  = (state_q == StIdle) ? (bus.writeM & ~bus.readM) : op_write_q;
  assign done_entry = (state_d == StDone) && (state_q != StDone);
  assign ram_addr   = (state_q == StIdle) ? live_idx : idx_q;
  assign ram_wdata  = (state_q == StIdle) ? bus.data_in : wline_q;
  assign ram_we     = done_entry & cur_write;
  assign ram_re     = done_entry & ~cur_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      count_q      <= '0;
      op_write_q   <= 1'b0;
      idx_q        <= '0;
      wline_q      <= '0;
      proto_err_q  <= 1'b0;
      num_reads_q  <= '0;
      num_writes_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      proto_err_q <= accept & bus.readM & bus.writeM;
      if (accept) begin
        // Read wins when both are requested; the write is dropped.
        op_write_q <= bus.writeM & ~bus.readM;
        idx_q      <= live_idx;
        wline_q    <= bus.data_in;
      end
      if (ram_we && num_writes_q != 16'hFFFF) num_writes_q <= num_writes_q + 16'd1;
      if (ram_re && num_reads_q  != 16'hFFFF) num_reads_q  <= num_reads_q + 16'd1;
    end
  end

  line_mem_array #(
    .LINE_ADDR_W (LINE_ADDR_W)
  ) u_array (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (ram_addr),
    .we      (ram_we),
    .re      (ram_re),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  assign bus.data_out  = ram_rdata;
  assign bus.mem_done  = (state_q == StDone);
  assign bus.busy      = (state_q != StIdle);
  assign bus.proto_err = proto_err_q;
  assign num_reads     = num_reads_q;
  assign num_writes    = num_writes_q;

endmodule

// File: tb/tb_line_memory.sv
// Bench for line_memory: a LATENCY=4 instance for the main scenarios and a
// LATENCY=1 / LINE_ADDR_W=12 instance for minimum latency and address wrap.
module tb_line_memory;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] nr, nw, nr1, nw1;

  always #5 clk = ~clk;

  line_memory_if mif ();
  line_memory_if m1if ();

  line_memory #(
    .LATENCY     (4),
    .LINE_ADDR_W (14)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (mif.slave),
    .num_reads  (nr),
    .num_writes (nw)
  );

  line_memory #(
    .LATENCY     (1),
    .LINE_ADDR_W (12)
  ) dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (m1if.slave),
    .num_reads  (nr1),
    .num_writes (nw1)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [63:0] model[int];
  logic [63:0] last_read = 64'h0;
  int          exp_reads = 0;
  int          exp_writes = 0;

  function automatic int line_idx(input logic [15:0] addr);
    return int'(addr[15:2]);
  endfunction

  // Drives one request, then scrambles address/data after acceptance, waits
  // (bounded) for mem_done and drops the request in the done cycle.
  task automatic issue(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [63:0] din, output int lat, output int perr_cnt,
                       output int perr_cyc, output logic [63:0] dout);
    lat = 0; perr_cnt = 0; perr_cyc = -1; dout = '0;
    @(negedge clk);
    mif.readM = rd; mif.writeM = wr; mif.address_memory = addr; mif.data_in = din;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        mif.data_in = ~din;
        mif.address_memory = addr ^ 16'h0100;
      end
      if (mif.proto_err) begin
        perr_cnt++;
        if (perr_cyc < 0) perr_cyc = c;
      end
      if (mif.mem_done) begin
        lat = c;
        dout = mif.data_out;
        break;
      end
    end
    mif.readM = 1'b0; mif.writeM = 1'b0;
  endtask

  task automatic test_reset();
    mif.readM = 0; mif.writeM = 0; mif.address_memory = '0; mif.data_in = '0;
    m1if.readM = 0; m1if.writeM = 0; m1if.address_memory = '0; m1if.data_in = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if ({mif.mem_done, mif.busy, mif.proto_err} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: done/busy/perr=%b expected 000", i,
                 {mif.mem_done, mif.busy, mif.proto_err});
      end
    end
    n_checks++;
    if (nr !== 16'd0 || nw !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters: reads=%0d writes=%0d expected 0/0", nr, nw);
    end
    n_checks++;
    if (mif.data_out !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data_out: got %h expected 0", mif.data_out);
    end
  endtask

  task automatic test_write_read();
    int lat, pc, pcy;
    logic [63:0] d, e;
    issue(1'b0, 1'b1, 16'h0040, 64'h1111_2222_3333_4444, lat, pc, pcy, d);
    model[line_idx(16'h0040)] = 64'h1111_2222_3333_4444;
    exp_writes++;
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL wr_latency: got %0d expected 4", lat); end
    n_checks++;
    if (d !== last_read) begin
      n_fail++; $display("FAIL wr_keeps_data_out: got %h expected %h", d, last_read);
    end
    n_checks++;
    if (nw !== 16'(exp_writes)) begin
      n_fail++; $display("FAIL wr_count: got %0d expected %0d", nw, exp_writes);
    end
    exp_q.push_back(model[line_idx(16'h0043)]);
    issue(1'b1, 1'b0, 16'h0043, 64'h0, lat, pc, pcy, d);
    exp_reads++;
    e = exp_q.pop_front();
    last_read = e;
    n_checks++;
    if (lat !== 4) begin n_fail++; $display("FAIL rd_latency: got %0d expected 4", lat); end
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL rd_data: got %h expected %h", d, e); end
    n_checks++;
    if (nr !== 16'(exp_reads)) begin
      n_fail++; $display("FAIL rd_count: got %0d expected %0d", nr, exp_reads);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    logic [63:0] e;
    @(negedge clk);
    mif.readM = 1'b1; mif.address_memory = 16'h0040;
    for (int k = 0; k < 3; k++) exp_q.push_back(model[line_idx(16'h0040)]);
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      n_checks++;
      if (mif.mem_done !== ((c % 5) == 4)) begin
        n_fail++; $display("FAIL b2b_done cycle %0d: got %b", c, mif.mem_done);
      end
      n_checks++;
      if (mif.busy !== ((c % 5) != 0)) begin
        n_fail++; $display("FAIL b2b_busy cycle %0d: got %b", c, mif.busy);
      end
      if (mif.mem_done && exp_q.size() > 0) begin
        dones++;
        e = exp_q.pop_front();
        n_checks++;
        if (mif.data_out !== e) begin
          n_fail++; $display("FAIL b2b_data cycle %0d: got %h expected %h", c, mif.data_out, e);
        end
      end
      if (c == 14) mif.readM = 1'b0;
    end
    exp_reads += 3;
    n_checks++;
    if (dones !== 3 || nr !== 16'(exp_reads)) begin
      n_fail++;
      $display("FAIL b2b_count: dones=%0d reads=%0d expected 3/%0d", dones, nr, exp_reads);
      exp_q.delete();
    end
  endtask

  task automatic test_proto();
    int lat, pc, pcy;
    logic [63:0] d, e;
    exp_q.push_back(model[line_idx(16'h0040)]);
    issue(1'b1, 1'b1, 16'h0040, 64'hFFFF_FFFF_FFFF_FFFF, lat, pc, pcy, d);
    exp_reads++;
    e = exp_q.pop_front();
    n_checks++;
    if (pc !== 1 || pcy !== 1) begin
      n_fail++; $display("FAIL proto_err_pulse: count=%0d cycle=%0d expected 1/1", pc, pcy);
    end
    n_checks++;
    if (lat !== 4 || d !== e) begin
      n_fail++; $display("FAIL proto_read: lat=%0d data=%h expected 4/%h", lat, d, e);
    end
    n_checks++;
    if (nr !== 16'(exp_reads) || nw !== 16'(exp_writes)) begin
      n_fail++;
      $display("FAIL proto_counts: reads=%0d writes=%0d expected %0d/%0d", nr, nw,
               exp_reads, exp_writes);
    end
    exp_q.push_back(model[line_idx(16'h0040)]);
    issue(1'b1, 1'b0, 16'h0040, 64'h0, lat, pc, pcy, d);
    exp_reads++;
    e = exp_q.pop_front();
    last_read = e;
    n_checks++;
    if (d !== e || pc !== 0) begin
      n_fail++; $display("FAIL proto_line_kept: got %h perr=%0d expected %h/0", d, pc, e);
    end
  endtask

  task automatic test_abort();
    int lat, pc, pcy;
    logic seen_done = 1'b0;
    logic [63:0] d, e;
    issue(1'b0, 1'b1, 16'h0080, 64'hAAAA_BBBB_CCCC_DDDD, lat, pc, pcy, d);
    model[line_idx(16'h0080)] = 64'hAAAA_BBBB_CCCC_DDDD;
    exp_writes++;
    n_checks++;
    if (d !== last_read) begin
      n_fail++; $display("FAIL abort_prep_data_out: got %h expected %h", d, last_read);
    end
    @(negedge clk);
    mif.writeM = 1'b1; mif.address_memory = 16'h0080; mif.data_in = 64'h5555_6666_7777_8888;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (mif.busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_busy_async: got %b expected 0", mif.busy);
    end
    repeat (2) begin
      @(negedge clk);
      if (mif.mem_done) seen_done = 1'b1;
    end
    mif.writeM = 1'b0;
    reset_n = 1'b1;
    exp_reads = 0; exp_writes = 0;
    repeat (6) begin
      @(negedge clk);
      if (mif.mem_done) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got 1 expected 0"); end
    n_checks++;
    if (nr !== 16'd0 || nw !== 16'd0 || mif.data_out !== 64'h0) begin
      n_fail++;
      $display("FAIL abort_reset_state: reads=%0d writes=%0d data=%h expected 0/0/0", nr, nw,
               mif.data_out);
    end
    exp_q.push_back(model[line_idx(16'h0080)]);
    issue(1'b1, 1'b0, 16'h0080, 64'h0, lat, pc, pcy, d);
    exp_reads++;
    e = exp_q.pop_front();
    n_checks++;
    if (d !== e) begin n_fail++; $display("FAIL abort_no_commit: got %h expected %h", d, e); end
  endtask

  task automatic test_latency1();
    logic [63:0] e;
    @(negedge clk);
    m1if.writeM = 1'b1; m1if.address_memory = 16'h4000; m1if.data_in = 64'h0123_4567_89AB_CDEF;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (m1if.mem_done !== 1'b1 || m1if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL lat1_wr_done: done/busy=%b%b expected 11", m1if.mem_done, m1if.busy);
    end
    m1if.writeM = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m1if.mem_done !== 1'b0 || m1if.busy !== 1'b0 || nw1 !== 16'd1) begin
      n_fail++;
      $display("FAIL lat1_wr_after: done=%b busy=%b writes=%0d expected 0/0/1", m1if.mem_done,
               m1if.busy, nw1);
    end
    // 0x4000 with a 12-bit line index wraps to line 0.
    exp_q.push_back(64'h0123_4567_89AB_CDEF);
    m1if.readM = 1'b1; m1if.address_memory = 16'h0002;
    @(posedge clk);
    @(negedge clk);
    m1if.readM = 1'b0;
    e = exp_q.pop_front();
    n_checks++;
    if (m1if.mem_done !== 1'b1 || m1if.data_out !== e) begin
      n_fail++;
      $display("FAIL lat1_rd_wrap: done=%b data=%h expected 1/%h", m1if.mem_done,
               m1if.data_out, e);
    end
    @(negedge clk);
    n_checks++;
    if (nr1 !== 16'd1 || m1if.mem_done !== 1'b0) begin
      n_fail++; $display("FAIL lat1_rd_count: reads=%0d done=%b expected 1/0", nr1,
                         m1if.mem_done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_proto();
    test_abort();
    test_latency1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
